// File: rtl/goomba_pool.sv
// Multi-slot walking-enemy manager: NUM_SLOTS independent walkers with spawn handshake,
// frame-rate motion (walk/fall/squish), Mario contact detection and a draw hit query.
module goomba_slot #(
    parameter int COORD_W       = 10,
    parameter int HALF_W        = 18,
    parameter int HALF_H        = 10,
    parameter int MARIO_HALF_H  = 20,
    parameter int X_MIN         = 120,
    parameter int X_MAX         = 519,
    parameter int Y_MAX         = 439,
    parameter int STEP_X        = 1,
    parameter int GRAVITY       = 1,
    parameter int VMAX          = 4,
    parameter int SQUISH_FRAMES = 30
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               fe,
    input  logic               kill,
    input  logic               load,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic               spawn_dir,
    input  logic [COORD_W-1:0] mario_x,
    input  logic [COORD_W-1:0] mario_y,
    input  logic               wall_l,
    input  logic               wall_r,
    input  logic               ground,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    output logic               alive,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               hit,
    output logic               squished,
    output logic               stomp,
    output logic               hurt
);
    localparam int SW   = COORD_W + 2;
    localparam int VY_W = $clog2(VMAX + 1);
    localparam int TM_W = $clog2(SQUISH_FRAMES + 1);
    localparam logic signed [SW-1:0] HW_S   = SW'(HALF_W);
    localparam logic signed [SW-1:0] HH_S   = SW'(HALF_H);
    localparam logic signed [SW-1:0] MHH_S  = SW'(MARIO_HALF_H);
    localparam logic signed [SW-1:0] XMIN_S = SW'(X_MIN);
    localparam logic signed [SW-1:0] XMAX_S = SW'(X_MAX);
    localparam logic signed [SW-1:0] YMAX_S = SW'(Y_MAX);
    localparam logic [VY_W:0]        VMAX_C = (VY_W + 1)'(VMAX);

    typedef enum logic [1:0] {IDLE, WALK, FALL, SQUISH} state_t;

    state_t              state, state_n;
    logic [COORD_W-1:0]  x, y, x_n, y_n;
    logic [VY_W-1:0]     vy, vy_n;
    logic [VY_W:0]       vy_sum;
    logic [TM_W-1:0]     timer, timer_n;
    logic                dir, dir_n, new_dir;
    logic signed [SW-1:0] sx, sy, lft, rgt, top, bot, mx, my, dx, dy, foot, head;
    logic                active, xov, stomp_c, hurt_c, out_c;

    // Widened signed geometry so boxes hanging off the playfield never wrap.
    assign sx     = $signed({2'b00, x});
    assign sy     = $signed({2'b00, y});
    assign mx     = $signed({2'b00, mario_x});
    assign my     = $signed({2'b00, mario_y});
    assign dx     = $signed({2'b00, draw_x});
    assign dy     = $signed({2'b00, draw_y});
    assign lft    = sx - HW_S;
    assign rgt    = sx + HW_S;
    assign top    = sy - HH_S;
    assign bot    = sy + HH_S;
    assign foot   = my + MHH_S;
    assign head   = my - MHH_S;
    assign active = (state == WALK) || (state == FALL);
    assign xov     = (lft <= mx) && (mx < rgt);
    assign stomp_c = xov && (foot == top);
    assign hurt_c  = xov && (foot > top) && (head < bot);
    assign out_c   = (rgt < XMIN_S) || (lft > XMAX_S) || (bot > YMAX_S);
    assign vy_sum  = {1'b0, vy} + (VY_W + 1)'(GRAVITY);
    assign stomp   = fe && active && stomp_c;
    assign hurt    = fe && active && !stomp_c && hurt_c;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            vy    <= '0;
            dir   <= 1'b0;
            timer <= '0;
        end else begin
            state <= state_n;
            x     <= x_n;
            y     <= y_n;
            vy    <= vy_n;
            dir   <= dir_n;
            timer <= timer_n;
        end
    end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        vy_n    = vy;
        dir_n   = dir;
        timer_n = timer;
        new_dir = dir;
        if (kill) begin
            state_n = IDLE;
            x_n     = '0;
            y_n     = '0;
            vy_n    = '0;
            dir_n   = 1'b0;
            timer_n = '0;
        end else if (load) begin
            state_n = WALK;
            x_n     = spawn_x;
            y_n     = spawn_y - COORD_W'(HALF_H);
            vy_n    = '0;
            dir_n   = spawn_dir;
        end else if (fe) begin
            case (state)
                WALK, FALL: begin
                    if (stomp_c) begin
                        state_n = SQUISH;
                        timer_n = TM_W'(SQUISH_FRAMES);
                        vy_n    = '0;
                    end else if (!hurt_c && out_c) begin
                        state_n = IDLE;
                    end else if (state == WALK) begin
                        if (!ground) begin
                            state_n = FALL;
                            vy_n    = '0;
                        end else if (!(wall_l && wall_r)) begin
                            new_dir = dir ? !wall_r : wall_l;
                            dir_n   = new_dir;
                            x_n     = new_dir ? x + COORD_W'(STEP_X) : x - COORD_W'(STEP_X);
                        end
                    end else begin
                        if (ground) begin
                            state_n = WALK;
                            vy_n    = '0;
                        end else begin
                            y_n  = y + COORD_W'(vy);
                            vy_n = (vy_sum > VMAX_C) ? VMAX_C[VY_W-1:0] : vy_sum[VY_W-1:0];
                        end
                    end
                end
                SQUISH: begin
                    if (timer == TM_W'(1)) state_n = IDLE;
                    else                   timer_n = timer - TM_W'(1);
                end
                default: ;
            endcase
        end
    end

    // A squished enemy only occupies the lower half of its box.
    always_comb begin
        alive    = (state != IDLE);
        squished = (state == SQUISH);
        pos_x    = alive ? x : '0;
        pos_y    = alive ? y : '0;
        hit      = alive && (lft <= dx) && (dx < rgt) && (dy < bot) &&
                   ((squished ? sy : top) <= dy);
    end
endmodule

module goomba_pool #(
    parameter int NUM_SLOTS     = 4,
    parameter int SLOT_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    parameter int COORD_W       = 10,
    parameter int HALF_W        = 18,
    parameter int HALF_H        = 10,
    parameter int MARIO_HALF_H  = 20,
    parameter int X_MIN         = 120,
    parameter int X_MAX         = 519,
    parameter int Y_MAX         = 439,
    parameter int STEP_X        = 1,
    parameter int GRAVITY       = 1,
    parameter int VMAX          = 4,
    parameter int SQUISH_FRAMES = 30
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_clk,
    input  logic                         spawn_valid,
    output logic                         spawn_ready,
    input  logic [COORD_W-1:0]           spawn_x,
    input  logic [COORD_W-1:0]           spawn_y,
    input  logic                         spawn_dir,
    input  logic                         kill_all,
    input  logic [COORD_W-1:0]           Mario_X_Pos,
    input  logic [COORD_W-1:0]           Mario_Y_Pos,
    input  logic [NUM_SLOTS-1:0]         wall_left,
    input  logic [NUM_SLOTS-1:0]         wall_right,
    input  logic [NUM_SLOTS-1:0]         ground_below,
    input  logic [COORD_W-1:0]           DrawX,
    input  logic [COORD_W-1:0]           DrawY,
    output logic [NUM_SLOTS*COORD_W-1:0] pos_x,
    output logic [NUM_SLOTS*COORD_W-1:0] pos_y,
    output logic [NUM_SLOTS-1:0]         alive,
    output logic                         draw_hit,
    output logic [SLOT_W-1:0]            draw_slot,
    output logic                         draw_squished,
    output logic                         stomp_pulse,
    output logic                         mario_hurt_pulse
);
    logic                 fd, fe, take, found;
    logic [NUM_SLOTS-1:0] grant, hit, squished, stomp_v, hurt_v;

    assign spawn_ready = |(~alive) && !kill_all && !Reset;
    assign take        = spawn_valid && spawn_ready;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!alive[i] && !found) begin
                grant[i] = take;
                found    = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        goomba_slot #(
            .COORD_W(COORD_W), .HALF_W(HALF_W), .HALF_H(HALF_H),
            .MARIO_HALF_H(MARIO_HALF_H), .X_MIN(X_MIN), .X_MAX(X_MAX),
            .Y_MAX(Y_MAX), .STEP_X(STEP_X), .GRAVITY(GRAVITY), .VMAX(VMAX),
            .SQUISH_FRAMES(SQUISH_FRAMES)
        ) u_slot (
            .Clk(Clk), .Reset(Reset), .fe(fe), .kill(kill_all), .load(grant[g]),
            .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir),
            .mario_x(Mario_X_Pos), .mario_y(Mario_Y_Pos),
            .wall_l(wall_left[g]), .wall_r(wall_right[g]), .ground(ground_below[g]),
            .draw_x(DrawX), .draw_y(DrawY), .alive(alive[g]),
            .pos_x(pos_x[g*COORD_W +: COORD_W]), .pos_y(pos_y[g*COORD_W +: COORD_W]),
            .hit(hit[g]), .squished(squished[g]), .stomp(stomp_v[g]), .hurt(hurt_v[g])
        );
    end

    // Walk downward so the lowest-index hit is the last (winning) assignment.
    always_comb begin
        draw_hit      = 1'b0;
        draw_slot     = '0;
        draw_squished = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                draw_hit      = 1'b1;
                draw_slot     = SLOT_W'(i);
                draw_squished = squished[i];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fd               <= 1'b0;
            fe               <= 1'b0;
            stomp_pulse      <= 1'b0;
            mario_hurt_pulse <= 1'b0;
        end else begin
            fd               <= frame_clk;
            fe               <= frame_clk && !fd;
            stomp_pulse      <= |stomp_v && !kill_all;
            mario_hurt_pulse <= |hurt_v && !kill_all;
        end
    end
endmodule

// File: tb/tb_goomba_pool.sv
// Directed bench for goomba_pool: per-frame behavioural model compared every cycle,
// plus hand-computed literal checks on key positions and pulses.
module tb_goomba_pool;
    localparam int N  = 4;
    localparam int CW = 10;

    logic            Clk = 1'b0, Reset = 1'b0, frame_clk = 1'b0;
    logic            spawn_valid = 1'b0, spawn_dir = 1'b0, kill_all = 1'b0;
    logic [CW-1:0]   spawn_x = '0, spawn_y = '0, Mario_X_Pos = '0, Mario_Y_Pos = '0;
    logic [CW-1:0]   DrawX = '0, DrawY = '0;
    logic [N-1:0]    wall_left = '0, wall_right = '0, ground_below = '1;
    logic            spawn_ready, draw_hit, draw_squished, stomp_pulse, mario_hurt_pulse;
    logic [N*CW-1:0] pos_x, pos_y;
    logic [N-1:0]    alive;
    logic [1:0]      draw_slot;

    goomba_pool dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .spawn_valid(spawn_valid),
        .spawn_ready(spawn_ready), .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir),
        .kill_all(kill_all), .Mario_X_Pos(Mario_X_Pos), .Mario_Y_Pos(Mario_Y_Pos),
        .wall_left(wall_left), .wall_right(wall_right), .ground_below(ground_below),
        .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y), .alive(alive),
        .draw_hit(draw_hit), .draw_slot(draw_slot), .draw_squished(draw_squished),
        .stomp_pulse(stomp_pulse), .mario_hurt_pulse(mario_hurt_pulse)
    );

    always #5 Clk = ~Clk;

    int vectors = 0, miscompares = 0;
    int stomp_seen = 0, hurt_seen = 0;
    bit chk_en = 0, upd = 0, e_stomp = 0, e_hurt = 0;
    // Model state: 0 idle, 1 walk, 2 fall, 3 squish
    int m_st[N], m_x[N], m_y[N], m_vy[N], m_dir[N], m_tm[N];
    int ylog[7];
    int exp_d[7] = '{0, 0, 1, 2, 3, 4, 4};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        bit any = 0;
        for (int s = 0; s < N; s++) if (m_st[s] == 0) any = 1;
        return any && !kill_all && !Reset;
    endfunction

    function automatic int lowest_idle();
        for (int s = 0; s < N; s++) if (m_st[s] == 0) return s;
        return -1;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < N; s++) begin
            m_st[s] = 0; m_x[s] = 0; m_y[s] = 0; m_vy[s] = 0; m_dir[s] = 0; m_tm[s] = 0;
        end
    endtask

    task automatic model_frame();
        int l, r, t, b, mx, my;
        bit xo;
        mx = int'(Mario_X_Pos);
        my = int'(Mario_Y_Pos);
        for (int s = 0; s < N; s++) begin
            if (m_st[s] == 3) begin
                if (m_tm[s] == 1) m_st[s] = 0;
                else m_tm[s]--;
            end else if (m_st[s] != 0) begin
                l = m_x[s] - 18; r = m_x[s] + 18; t = m_y[s] - 10; b = m_y[s] + 10;
                xo = (l <= mx) && (mx < r);
                if (xo && (my + 20 == t)) begin
                    m_st[s] = 3; m_tm[s] = 30; m_vy[s] = 0; e_stomp = 1;
                    continue;
                end
                if (xo && (my + 20 > t) && (my - 20 < b)) e_hurt = 1;
                else if (r < 120 || l > 519 || b > 439) begin
                    m_st[s] = 0;
                    continue;
                end
                if (m_st[s] == 1) begin
                    if (!ground_below[s]) begin
                        m_st[s] = 2; m_vy[s] = 0;
                    end else if (!(wall_left[s] && wall_right[s])) begin
                        if (m_dir[s] == 0 && wall_left[s]) m_dir[s] = 1;
                        else if (m_dir[s] == 1 && wall_right[s]) m_dir[s] = 0;
                        m_x[s] = (m_x[s] + (m_dir[s] == 1 ? 1 : -1)) & 1023;
                    end
                end else begin
                    if (ground_below[s]) begin
                        m_st[s] = 1; m_vy[s] = 0;
                    end else begin
                        m_y[s]  = (m_y[s] + m_vy[s]) & 1023;
                        m_vy[s] = (m_vy[s] + 1 > 4) ? 4 : m_vy[s] + 1;
                    end
                end
            end
        end
    endtask

    // One clock: sample control inputs before the edge, update the model after it.
    task automatic tick();
        bit take, kl, rs;
        int idx;
        rs   = Reset;
        kl   = kill_all;
        take = spawn_valid && m_ready();
        idx  = lowest_idle();
        @(posedge Clk);
        #1;
        e_stomp = 0;
        e_hurt  = 0;
        if (rs || kl) model_clear();
        else begin
            if (upd) model_frame();
            if (take) begin
                m_st[idx] = 1; m_x[idx] = int'(spawn_x); m_y[idx] = (int'(spawn_y) - 10) & 1023;
                m_dir[idx] = int'(spawn_dir); m_vy[idx] = 0; m_tm[idx] = 0;
            end
        end
    endtask

    // Slot update lands on the second clock after frame_clk rises.
    task automatic frame();
        frame_clk = 1'b1;
        tick();
        upd = 1;
        tick();
        upd = 0;
        tick();
        frame_clk = 1'b0;
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic spawn(input int x, input int y, input bit d);
        spawn_x = CW'(x); spawn_y = CW'(y); spawn_dir = d; spawn_valid = 1'b1;
        tick();
        spawn_valid = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    always @(negedge Clk) begin
        if (stomp_pulse === 1'b1) stomp_seen++;
        if (mario_hurt_pulse === 1'b1) hurt_seen++;
    end

    always @(negedge Clk) begin : compare
        logic [N*CW-1:0] ex, ey;
        logic [N-1:0]    ea;
        logic            dh, dq;
        logic [1:0]      ds;
        int              l, r, t, b, dx, dy;
        if (chk_en) begin
            ex = '0; ey = '0; ea = '0; dh = 0; dq = 0; ds = '0;
            dx = int'(DrawX); dy = int'(DrawY);
            for (int s = 0; s < N; s++) begin
                if (m_st[s] != 0) begin
                    ea[s] = 1'b1;
                    ex[s*CW +: CW] = m_x[s][CW-1:0];
                    ey[s*CW +: CW] = m_y[s][CW-1:0];
                    l = m_x[s] - 18; r = m_x[s] + 18; b = m_y[s] + 10;
                    t = (m_st[s] == 3) ? m_y[s] : m_y[s] - 10;
                    if (!dh && l <= dx && dx < r && t <= dy && dy < b) begin
                        dh = 1; ds = 2'(s); dq = (m_st[s] == 3);
                    end
                end
            end
            check("alive", alive, ea);
            check("pos_x", pos_x, ex);
            check("pos_y", pos_y, ey);
            check("spawn_ready", spawn_ready, m_ready());
            check("draw_hit", draw_hit, dh);
            check("draw_slot", draw_slot, ds);
            check("draw_squished", draw_squished, dq);
            check("stomp_pulse", stomp_pulse, e_stomp);
            check("hurt_pulse", mario_hurt_pulse, e_hurt);
        end
    end

    initial begin
        model_clear();
        Reset = 1'b1;
        tick();
        chk_en = 1;
        tick();
        Reset = 1'b0;
        tick();
        check("rst_alive", alive, 4'b0000);
        check("rst_ready", spawn_ready, 1'b1);

        // 1: spawn and walk left
        spawn(200, 300, 0);
        check("t1_x0", pos_x[0 +: CW], 200);
        check("t1_y0", pos_y[0 +: CW], 290);
        check("t1_alive", alive, 4'b0001);
        frames(3);
        check("t1_x3", pos_x[0 +: CW], 197);
        check("t1_model_x3", m_x[0], 197);
        check("t1_y3", pos_y[0 +: CW], 290);
        DrawX = 197; DrawY = 280;
        tick();
        check("t1_draw_top", draw_hit, 1'b1);
        DrawY = 300;
        tick();
        check("t1_draw_bot", draw_hit, 1'b0);

        // 2: walls
        wall_left = 4'b0001;
        frame();
        check("t2_bounce", pos_x[0 +: CW], 198);
        wall_right = 4'b0001;
        frame();
        check("t2_both", pos_x[0 +: CW], 198);
        wall_left = '0; wall_right = '0;
        frame();
        check("t2_right", pos_x[0 +: CW], 199);

        // 3: fall and land
        ground_below = 4'b1110;
        for (int i = 0; i < 7; i++) begin
            ylog[i] = int'(pos_y[0 +: CW]);
            frame();
            check("t3_dy", int'(pos_y[0 +: CW]) - ylog[i], exp_d[i]);
        end
        check("t3_y", pos_y[0 +: CW], 304);
        ground_below = '1;
        frame();
        check("t3_land_y", pos_y[0 +: CW], 304);
        check("t3_land_x", pos_x[0 +: CW], 199);
        frame();
        check("t3_walk_x", pos_x[0 +: CW], 200);

        // hurt: Mario overlapping side, motion continues
        hurt_seen = 0;
        Mario_X_Pos = 200; Mario_Y_Pos = 304;
        frame();
        check("t3_hurt_cnt", hurt_seen, 1);
        check("t3_hurt_x", pos_x[0 +: CW], 201);
        Mario_X_Pos = 0; Mario_Y_Pos = 0;

        // 4: stomp and squish
        do_reset();
        spawn(200, 300, 0);
        stomp_seen = 0;
        Mario_X_Pos = 205; Mario_Y_Pos = 260;
        frame();
        Mario_X_Pos = 0; Mario_Y_Pos = 0;
        check("t4_stomp_cnt", stomp_seen, 1);
        DrawX = 200; DrawY = 289;
        tick();
        check("t4_draw_289", draw_hit, 1'b0);
        DrawY = 290;
        tick();
        check("t4_draw_290", draw_hit, 1'b1);
        check("t4_draw_sq", draw_squished, 1'b1);
        DrawY = 299;
        tick();
        check("t4_draw_299", draw_hit, 1'b1);
        DrawY = 300;
        tick();
        check("t4_draw_300", draw_hit, 1'b0);
        frames(29);
        check("t4_alive29", alive[0], 1'b1);
        frame();
        check("t4_idle30", alive[0], 1'b0);

        // 5: fill, stomp slot2, held spawn lands there
        do_reset();
        spawn(200, 300, 0);
        spawn(260, 300, 0);
        spawn(320, 300, 0);
        spawn(380, 300, 0);
        check("t5_full", spawn_ready, 1'b0);
        spawn_x = 440; spawn_y = 350; spawn_dir = 1'b1; spawn_valid = 1'b1;
        Mario_X_Pos = 320; Mario_Y_Pos = 260;
        frame();
        Mario_X_Pos = 0; Mario_Y_Pos = 0;
        frames(29);
        check("t5_ready29", spawn_ready, 1'b0);
        frame();
        spawn_valid = 1'b0;
        check("t5_alive", alive, 4'b1111);
        check("t5_x2", pos_x[2*CW +: CW], 440);
        check("t5_y2", pos_y[2*CW +: CW], 340);
        check("t5_x0", pos_x[0 +: CW], 169);

        // 6: kill_all beats spawn; reset mid-fall
        kill_all = 1'b1; spawn_valid = 1'b1;
        #1;
        check("t6_kill_ready", spawn_ready, 1'b0);
        tick();
        kill_all = 1'b0; spawn_valid = 1'b0;
        tick();
        check("t6_kill_alive", alive, 4'b0000);
        spawn(300, 300, 1);
        ground_below = 4'b1110;
        frames(3);
        DrawX = 300; DrawY = 291;
        tick();
        check("t6_fall_hit", draw_hit, 1'b1);
        Reset = 1'b1;
        tick();
        check("t6_rst_alive", alive, 4'b0000);
        check("t6_rst_px", pos_x, '0);
        check("t6_rst_py", pos_y, '0);
        check("t6_rst_draw", draw_hit, 1'b0);
        Reset = 1'b0;
        ground_below = '1;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
